// File: rtl/pinball_pkg.sv
// Shared definitions for the pinball bonus-target logic: target count,
// controller FSM states, target index type and the target-pick helper.
package pinball_pkg;

   localparam int NUM_TARGETS = 10;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      CAPTURE,
      LIT,
      AWARD
   } state_t;

   typedef logic [3:0] target_idx_t;

   // Fold a raw 4-bit random value onto 0..9, then step past the previous
   // target so the same lamp is never lit twice in a row within a round.
   function automatic target_idx_t pick_target(input logic [3:0] raw,
                                               input target_idx_t prev,
                                               input logic prev_valid);
      target_idx_t t;
      t = (raw > 4'd9) ? raw - 4'd10 : raw;
      if (prev_valid && (t == prev))
         t = (t == 4'd9) ? 4'd0 : t + 4'd1;
      return t;
   endfunction

endpackage

// File: rtl/bonus_timer.sv
// Lit-window down-counter: loads a start value, counts down to zero and
// parks there; expired flags the last cycle of the window.
module bonus_timer #(
   parameter int WIDTH = 26
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] value,
   output logic             expired
);

   logic [WIDTH-1:0] count;

   // Load on request, otherwise decrement until the counter reaches zero.
   always_ff @(posedge clk) begin
      if (reset)
         count <= '0;
      else if (load)
         count <= value;
      else if (count != '0)
         count <= count - 1'b1;
   end

   assign expired = (count == '0);

endmodule

// File: rtl/bonus_target_controller.sv
// Bonus-round controller: requests a random target, lights it for a fixed
// window, scores hits with a streak multiplier and ends the round on a miss.
module bonus_target_controller
   import pinball_pkg::*;
#(
   parameter int LIT_CYCLES  = 50_000_000,
   parameter int BASE_POINTS = 10
) (
   input  logic                   clk,
   input  logic                   resetN,
   input  logic                   startBonus,
   input  logic [NUM_TARGETS-1:0] targetHit,
   input  logic [3:0]             randomNumber,
   output logic                   getRandomNumber,
   output logic [NUM_TARGETS-1:0] litTarget,
   output logic                   bonusActive,
   output logic                   awardValid,
   output logic [7:0]             awardPoints,
   output logic [2:0]             streak
);

   localparam int TW = $clog2(LIT_CYCLES);

   state_t                 state, state_next;
   target_idx_t            cur_target, prev_target, chosen;
   logic                   prev_valid;
   logic                   lit_hit, timer_expired;
   logic [2:0]             streak_inc;

   logic                   req_next, active_next, valid_next, prev_valid_next;
   logic [NUM_TARGETS-1:0] lit_next;
   logic [7:0]             points_next;
   logic [2:0]             streak_next;
   target_idx_t            cur_next, prev_next;

   assign chosen     = pick_target(randomNumber, prev_target, prev_valid);
   assign lit_hit    = |(targetHit & litTarget);
   assign streak_inc = (streak == 3'd7) ? 3'd7 : streak + 3'd1;

   // Window counter is loaded as the lamp turns on, so it reads zero on the
   // final lit cycle.
   bonus_timer #(.WIDTH(TW)) u_timer (
      .clk     (clk),
      .reset   (resetN),
      .load    (state == CAPTURE),
      .value   (TW'(LIT_CYCLES - 1)),
      .expired (timer_expired)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (resetN)
         state <= IDLE;
      else
         state <= state_next;
   end

   // Next-state logic; a lit hit wins over a simultaneous timeout.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (startBonus) state_next = REQ;
         REQ:     state_next = CAPTURE;
         CAPTURE: state_next = LIT;
         LIT: begin
            if (lit_hit)            state_next = AWARD;
            else if (timer_expired) state_next = IDLE;
         end
         AWARD:   state_next = REQ;
         default: state_next = IDLE;
      endcase
   end

   // Next values of the registered outputs; strobes default low, rest hold.
   always_comb begin
      req_next        = 1'b0;
      valid_next      = 1'b0;
      active_next     = bonusActive;
      lit_next        = litTarget;
      points_next     = awardPoints;
      streak_next     = streak;
      cur_next        = cur_target;
      prev_next       = prev_target;
      prev_valid_next = prev_valid;
      case (state)
         IDLE: begin
            if (startBonus) begin
               req_next        = 1'b1;
               active_next     = 1'b1;
               streak_next     = 3'd0;
               prev_valid_next = 1'b0;
            end
         end
         CAPTURE: begin
            cur_next = chosen;
            lit_next = {{(NUM_TARGETS-1){1'b0}}, 1'b1} << chosen;
         end
         LIT: begin
            if (lit_hit) begin
               lit_next        = '0;
               prev_next       = cur_target;
               prev_valid_next = 1'b1;
               streak_next     = streak_inc;
               valid_next      = 1'b1;
               points_next     = 8'(BASE_POINTS * streak_inc);
            end else if (timer_expired) begin
               lit_next    = '0;
               active_next = 1'b0;
               streak_next = 3'd0;
            end
         end
         AWARD:   req_next = 1'b1;
         default: ;
      endcase
   end

   // Output and round-context registers.
   always_ff @(posedge clk) begin
      if (resetN) begin
         getRandomNumber <= 1'b0;
         litTarget       <= '0;
         bonusActive     <= 1'b0;
         awardValid      <= 1'b0;
         awardPoints     <= 8'd0;
         streak          <= 3'd0;
         cur_target      <= '0;
         prev_target     <= '0;
         prev_valid      <= 1'b0;
      end else begin
         getRandomNumber <= req_next;
         litTarget       <= lit_next;
         bonusActive     <= active_next;
         awardValid      <= valid_next;
         awardPoints     <= points_next;
         streak          <= streak_next;
         cur_target      <= cur_next;
         prev_target     <= prev_next;
         prev_valid      <= prev_valid_next;
      end
   end

endmodule

// File: tb/tb_bonus_target_controller.sv
// Directed plus randomized bench for bonus_target_controller, checked
// against a round-level reference model (target choice, streak, points).
module tb_bonus_target_controller;

   logic       clk = 1'b0;
   logic       resetN;
   logic       startBonus;
   logic [9:0] targetHit;
   logic [3:0] randomNumber = 4'd0;
   logic       getRandomNumber;
   logic [9:0] litTarget;
   logic       bonusActive;
   logic       awardValid;
   logic [7:0] awardPoints;
   logic [2:0] streak;

   logic [3:0] next_src;

   int n_vec = 0;
   int n_err = 0;

   // Reference model state.
   int m_streak     = 0;
   int m_points     = 0;
   int m_prev       = 0;
   bit m_prev_valid = 1'b0;

   bonus_target_controller #(.LIT_CYCLES(8), .BASE_POINTS(10)) dut (
      .clk             (clk),
      .resetN          (resetN),
      .startBonus      (startBonus),
      .targetHit       (targetHit),
      .randomNumber    (randomNumber),
      .getRandomNumber (getRandomNumber),
      .litTarget       (litTarget),
      .bonusActive     (bonusActive),
      .awardValid      (awardValid),
      .awardPoints     (awardPoints),
      .streak          (streak)
   );

   always #5 clk = ~clk;

   // Random source: registers the bench-chosen value on the strobe edge.
   always @(posedge clk) if (getRandomNumber) randomNumber <= next_src;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_strobe"}, getRandomNumber, 0);
      check({tag, "_lamp"},   litTarget, 0);
      check({tag, "_active"}, bonusActive, 0);
      check({tag, "_valid"},  awardValid, 0);
      check({tag, "_points"}, awardPoints, 0);
      check({tag, "_streak"}, streak, 0);
   endtask

   // Issue startBonus from IDLE; afterwards the DUT sits in its request cycle.
   task automatic start_round();
      startBonus = 1'b1;
      tick();
      check("start_strobe", getRandomNumber, 1);
      check("start_active", bonusActive, 1);
      check("start_streak", streak, 0);
      check("start_lamp",   litTarget, 0);
      check("start_points_hold", awardPoints, m_points);
      startBonus   = 1'b0;
      m_streak     = 0;
      m_prev_valid = 1'b0;
   endtask

   // Serve one target from the request cycle. hit_at = 1..8 hits the lamp
   // in that lit cycle; 0 lets the window run out.
   task automatic serve(input int v, input int hit_at);
      int r;
      logic [9:0] lamp, noise;
      next_src = 4'(v);
      r = (v > 9) ? v - 10 : v;
      if (m_prev_valid && r == m_prev) r = (r + 1) % 10;
      lamp = '0;
      lamp[r] = 1'b1;
      tick();
      check("cap_lamp",   litTarget, 0);
      check("cap_strobe", getRandomNumber, 0);
      tick();
      check("lit_lamp",   litTarget, lamp);
      check("lit_active", bonusActive, 1);
      for (int c = 1; c <= 8; c++) begin
         noise = 10'($urandom) & ~lamp;
         targetHit = (c == hit_at) ? (lamp | noise) : noise;
         tick();
         targetHit = '0;
         if (c == hit_at) begin
            m_streak     = (m_streak < 7) ? m_streak + 1 : 7;
            m_points     = 10 * m_streak;
            m_prev       = r;
            m_prev_valid = 1'b1;
            check("award_valid",  awardValid, 1);
            check("award_points", awardPoints, m_points);
            check("award_streak", streak, m_streak);
            check("award_lamp",   litTarget, 0);
            tick();
            check("award_end",    awardValid, 0);
            check("next_strobe",  getRandomNumber, 1);
            check("points_hold",  awardPoints, m_points);
            return;
         end else if (c < 8) begin
            check("lit_hold",     litTarget, lamp);
            check("lit_no_award", awardValid, 0);
         end else begin
            m_streak = 0;
            check("miss_lamp",   litTarget, 0);
            check("miss_active", bonusActive, 0);
            check("miss_streak", streak, 0);
            check("miss_award",  awardValid, 0);
         end
      end
   endtask

   initial begin
      resetN     = 1'b1;
      startBonus = 1'b0;
      targetHit  = '0;
      next_src   = 4'd0;
      tick();
      tick();
      check_all_zero("reset");
      resetN = 1'b0;
      tick();
      check_all_zero("idle");

      // Directed round: repeat avoidance, folding, saturation, hit+timeout, miss.
      start_round();
      serve(4, 3);
      serve(4, 2);
      serve(9, 1);
      serve(9, 1);
      serve(13, 1);
      serve(0, 4);
      serve(15, 5);
      serve(10, 8);
      serve(6, 0);

      // startBonus held through a round: ignored while active, restarts after a miss.
      start_round();
      serve(1, 2);
      startBonus = 1'b1;
      serve(3, 1);
      serve(5, 0);
      tick();
      check("restart_strobe", getRandomNumber, 1);
      check("restart_active", bonusActive, 1);
      check("restart_streak", streak, 0);
      startBonus   = 1'b0;
      m_streak     = 0;
      m_prev_valid = 1'b0;
      serve(3, 1);
      serve(8, 0);

      // Reset in the middle of a lit window.
      start_round();
      serve(2, 1);
      next_src = 4'd7;
      tick();
      tick();
      check("pre_reset_lamp", litTarget, 10'h080);
      resetN = 1'b1;
      tick();
      check_all_zero("midlit_reset");
      resetN = 1'b0;
      m_streak = 0; m_points = 0; m_prev = 0; m_prev_valid = 1'b0;
      tick();

      // Randomized rounds.
      for (int k = 0; k < 15; k++) begin
         int n;
         start_round();
         n = $urandom_range(1, 6);
         for (int j = 0; j < n; j++)
            serve($urandom_range(0, 15), $urandom_range(1, 8));
         serve($urandom_range(0, 15), 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
